// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the parametrised synchronous
//                RAM. The two-state controller encoding and the rdwr
//                encodings are defined here.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Controller states: memory being zeroed, or accepting accesses
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // rdwr encodings
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_ctrl
//  Description : Clear sequencer for ram_param_sync. It walks every address
//                once, issuing a zero write per cycle, and then reports the
//                RAM as ready. It runs after reset (when CLEAR_ON_RESET=1) and
//                whenever clr is seen while idle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr           - clear request, honoured only while idle
//                ready         - registered, high while idle
//                clr_we        - zero-write enable for the array
//                clr_addr      - address of the word being zeroed
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Last address of the array, i.e. DEPTH-1
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == C_LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
    // ready is registered so it tracks the state being entered
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      ready_q   <= !CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;

endmodule
`default_nettype wire

// File: rtl/ram_param_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ram_param_sync
//  Description : Parametrised synchronous single-port RAM of 2**ADDR_W words
//                by DATA_W bits, with a registered read port, a one-cycle
//                read-valid strobe, a ready flag and a hardware clear.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en, rdwr      - access enable, 1=read / 0=write
//                ad_in         - word address
//                data_in       - write data
//                clr           - clear request (idle only)
//                data_out      - registered read data, holds last read
//                rd_valid      - one-cycle strobe when data_out is updated
//                ready         - high when accesses are accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_param_sync
  import ram_pkg::*;
#(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rdwr,
  input  logic [ADDR_W-1:0] ad_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;

  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_access;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  ram_clear_ctrl #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  always_comb begin
    // A clear request wins over a same-cycle access; reset blocks all writes
    w_access   = en && w_ready && !clr && !rst;
    w_wr_en    = !rst && (w_clr_we || (w_access && (rdwr == WR)));
    w_wr_addr  = w_clr_we ? w_clr_addr : ad_in;
    w_wr_data  = w_clr_we ? '0 : data_in;
    rd_valid_d = w_access && (rdwr == RD);
    data_out_d = rd_valid_d ? mem_q[ad_in] : data_out_q;
  end

  // Array has no reset; it is only zeroed by the clear sequence
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign ready    = w_ready;

endmodule
`default_nettype wire

// File: doc/ram_param_sync.md
Name: ram_param_sync

Overview:
Parametrised synchronous single-port RAM, DEPTH words of DATA_W bits each. It generalises the fixed 4x4 binary-cell RAM and adds:
- a registered read port with a one-cycle read-valid strobe;
- a ready flag;
- a hardware clear sequencer that zeroes every word after reset or on request.

It is the storage primitive for register files and small buffers in later assignments.

Parameters:
DATA_W, 4, word width in bits (>=1)
ADDR_W, 2, address width in bits (>=1); DEPTH = 2**ADDR_W, a derived localparam that is not overridable
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE with memory contents undefined

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  access enable; an access is accepted only when en=1 and ready=1
rdwr  input  1  1 = read, 0 = write
ad_in  input  ADDR_W  word address
data_in  input  DATA_W  write data
clr  input  1  clear request pulse, sampled in IDLE only
data_out  output  DATA_W  registered read data; holds the last value read
rd_valid  output  1  high for exactly one cycle when data_out is updated by a read
ready  output  1  high when the RAM accepts accesses (IDLE)

Behaviour:
- Reset (rst=1 at a clock edge), which overrides everything including mid-clear:
  - data_out=0, rd_valid=0, clr_cnt=0.
  - If CLEAR_ON_RESET=1: state=CLEAR, ready=0. Otherwise: state=IDLE, ready=1.
  - Memory array is not reset directly; it is only written by the CLEAR state.
- The FSM has two states, CLEAR and IDLE. ready is registered and equals (state==IDLE).
- CLEAR state:
  - Each cycle: mem[clr_cnt]<=0 and clr_cnt<=clr_cnt+1.
  - When clr_cnt==DEPTH-1: go to IDLE, clr_cnt<=0.
  - Clear takes exactly DEPTH cycles. ready rises on the edge after the last word is written, i.e. ready=1 is first visible DEPTH cycles after the reset edge is released.
  - en, clr and data inputs are ignored. rd_valid=0; data_out holds its value.
- IDLE, read (en=1, rdwr=1):
  - data_out<=mem[ad_in], rd_valid<=1 at the same edge, so latency is 1 cycle.
  - Back-to-back reads give rd_valid high on consecutive cycles.
- IDLE, write (en=1, rdwr=0):
  - mem[ad_in]<=data_in at the edge. rd_valid<=0; data_out unchanged.
  - A read of the same address on the next cycle returns the new data; no bypass path is needed.
- IDLE, en=0: no memory change; rd_valid<=0.
- IDLE, clr=1:
  - Go to CLEAR, with clr_cnt starting at 0. ready=0 from the next cycle.
  - clr takes priority over an access in the same cycle; that access is dropped, with no write and no rd_valid.
- data_out is never forced to 0 when idle. A consumer must qualify it with rd_valid.
- Width rules: ad_in is exactly ADDR_W bits, so every address is in range and there is no out-of-range case. clr_cnt is ADDR_W bits and its terminal compare is against DEPTH-1.

Decomposition:
- Shared package ram_pkg:
  - state enum {ST_CLEAR, ST_IDLE};
  - constants RD=1'b1 and WR=1'b0 for rdwr.
- One natural sub-module, ram_clear_ctrl, containing the FSM, clr_cnt and ready. It outputs the clear write enable and address.
- The top level muxes between the clear write and the user write, and holds the array and the data_out/rd_valid registers.

Test Plan:
1. Reset release with DEPTH=4, CLEAR_ON_RESET=1 -> ready=0 for 4 cycles, then 1; reads of addresses 0..3 all return 0 with rd_valid=1 one cycle after each request.
2. In IDLE, write 0xA@1, 0x5@2, 0xF@3, then read 1,2,3 back-to-back -> data_out=0xA,0x5,0xF on consecutive cycles, rd_valid high for 3 cycles then low; data_out stays 0xF afterwards.
3. Write 0x3@0, then read 0 on the next cycle -> data_out=0x3 with rd_valid=1; a write cycle leaves rd_valid=0 and data_out unchanged.
4. Assert clr together with en=1, rdwr=0, data 0x9@2 -> write dropped, ready=0 for 4 cycles, then read 2 returns 0; en/data pulses during CLEAR have no effect.
5. Assert rst at the 2nd cycle of CLEAR -> counter restarts; ready first rises 4 cycles after rst deasserts, not earlier.
6. DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=0 -> ready=1 on the cycle after reset; write 0xC3@15 then read 15 returns 0xC3; read@0 then read@15 confirms no address wrap or aliasing.
